rng_state_ctrl: RTL and testbench
=================================

# rng_state_ctrl

Sequencing and access controller for the byte-writable RNG state register file. It loads a NUM_BYTES seed from a byte-serial stream and shares the file's single write port between the seed loader and the generator core's state-update requests, with seeding taking priority. It also counts accepted updates and raises a reseed request at a programmable interval. It sits between the seed source, the generator core and the state register file, and drives the file's `w_en_bytes`/`w_data_bytes` directly.

## Interface

- `NUM_BYTES`, 32, state size in bytes.
- `TOTAL_BITS`, 8*NUM_BYTES, flattened state width.
- `RESEED_INTERVAL`, 0, number of accepted updates before `reseed_req` is raised; 0 disables it.

Ports:

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seed_start`  in  1  single-cycle pulse that begins a (re)seed.
- `seed_valid`  in  1  seed byte valid.
- `seed_data`  in  8  seed byte; byte 0 first.
- `seed_ready`  out  1  loader accepts a byte.
- `upd_valid`  in  1  generator update request.
- `upd_mask`  in  NUM_BYTES  per-byte update mask.
- `upd_data`  in  TOTAL_BITS  update data; bits [8*i +: 8] go to byte i.
- `upd_ready`  out  1  update accepted.
- `w_en_bytes`  out  NUM_BYTES  registered byte write enables to the state file.
- `w_data_bytes`  out  TOTAL_BITS  registered write data to the state file.
- `seeded`  out  1  state holds a complete seed.
- `reseed_req`  out  1  update interval reached.

## Operation

- FSM states: IDLE, LOAD, DRAIN, READY.
- Reset values: state=IDLE, byte index=0, update count=0. All outputs are 0: `w_en_bytes`, `w_data_bytes`, `seed_ready`, `upd_ready`, `seeded`, `reseed_req`.
- IDLE, on `seed_start`: go to LOAD and clear the byte index.
- LOAD:
  - `seed_ready`=1.
  - On a seed handshake (`seed_valid` & `seed_ready`), write byte[idx] = `seed_data`, then increment idx.
  - The handshake that accepts idx=NUM_BYTES-1 moves the FSM to DRAIN.
- DRAIN: lasts one cycle while the last byte is written, then goes to READY.
- `seeded` is set on entry to READY and cleared on entry to LOAD.
- READY:
  - `upd_ready` = `upd_valid` & !`seed_start`.
  - On an accepted update, write all bytes whose mask bit is set.
  - `seed_start` moves the FSM to LOAD.
- Priority: seeding beats updates. If `seed_start` and `upd_valid` coincide in READY, the update is not accepted.
- `upd_ready`=0 in IDLE, LOAD and DRAIN.
- `seed_start` is ignored in LOAD and DRAIN; it does not restart the load.
- An accepted update with `upd_mask`=0 is legal:
  - it produces all-zero `w_en_bytes`;
  - it still counts as an accepted update.
- Update counter:
  - 32 bits; increments on each accepted update and saturates at all-ones.
  - `reseed_req` is set when the count reaches RESEED_INTERVAL (RESEED_INTERVAL≠0).
  - The counter and `reseed_req` are cleared on entry to LOAD.
  - Updates remain permitted while `reseed_req` is high.
- Write output: `w_data_bytes` carries the seed byte replicated into every byte lane. Only the enabled lane matters.
- Reset mid-load: everything returns to the reset values immediately. Bytes already written to the state file are not cleared by this block.

## Timing

- Handshake accepted in cycle N → `w_en_bytes`/`w_data_bytes` asserted in cycle N+1 → state file updated at the end of N+1.
- Write enables are single-cycle pulses, all zero when no handshake occurred the previous cycle.
- Full seed takes NUM_BYTES accepted bytes:
  - last accept in cycle N, DRAIN in N+1, `seeded`=1 from N+2;
  - the state file is complete when `seeded` rises.
- `seed_ready` and `upd_ready` depend combinationally on the FSM state. `upd_ready` also depends combinationally on `upd_valid` and `seed_start`.
- `reseed_req` rises in the cycle after the accepting handshake that makes the count equal RESEED_INTERVAL.
- Seed backpressure: `seed_valid` low stalls LOAD indefinitely with no timeout.

## Structure

- Shared package `rng_pkg`:
  - FSM state enum (IDLE, LOAD, DRAIN, READY);
  - default NUM_BYTES;
  - the update-counter width constant (32).
- Byte index width is $clog2(NUM_BYTES).
- One natural sub-module, `rng_write_mux`: registered selection of seed vs update write, producing `w_en_bytes`/`w_data_bytes` from a one-hot byte index or mask.
- The FSM and counters stay in the top.

## Test plan

- Reset then seed 0x00..0x1F: `w_en_bytes` = 1<<k one cycle after each accept; `seeded`=1 two cycles after the 32nd accept; state file reads bytes 0x00..0x1F.
- Seed with `seed_valid` toggled every other cycle: exactly 32 writes, the index advances only on handshakes, and `seeded` rises correctly.
- READY, update with mask=0x0000_0003 and data byte0=0xAA, byte1=0x55: only bytes 0 and 1 change, one cycle after `upd_ready`.
- READY, `seed_start` coincident with `upd_valid`: `upd_ready`=0, the FSM enters LOAD, `seeded` drops next cycle, and the update stays pending until the reload completes.
- RESEED_INTERVAL=4: four accepted updates (one with mask 0) → `reseed_req`=1 the next cycle; a fifth update is still accepted; reseeding clears `reseed_req`.
- `rst_n` asserted after 10 seed bytes: all outputs 0 immediately; `seed_start` is required again; the next load begins at byte 0.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG state sequencing logic.
// Imported by the controller and its write mux.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } rng_state_e;

  localparam int RNG_NUM_BYTES = 32;
  localparam int RNG_CNT_W     = 32;

endpackage

// File: rtl/rng_write_mux.sv
// Registered write-port mux for the RNG state file.
// Seed writes hit one byte lane; updates hit every masked lane.
module rng_write_mux
  import rng_pkg::*;
#(
  parameter int NUM_BYTES  = RNG_NUM_BYTES,
  parameter int TOTAL_BITS = 8*NUM_BYTES,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_we,
  input  logic [IDX_W-1:0]      seed_idx,
  input  logic [7:0]            seed_byte,
  input  logic                  upd_we,
  input  logic [NUM_BYTES-1:0]  upd_mask,
  input  logic [TOTAL_BITS-1:0] upd_data,
  output logic [NUM_BYTES-1:0]  w_en_bytes,
  output logic [TOTAL_BITS-1:0] w_data_bytes
);

  logic [NUM_BYTES-1:0]  en_d;
  logic [TOTAL_BITS-1:0] data_d;

  // seed and update writes are mutually exclusive by FSM state
  always_comb begin
    en_d   = '0;
    data_d = '0;
    unique case (1'b1)
      seed_we: begin
        en_d   = NUM_BYTES'(1) << seed_idx;
        data_d = {NUM_BYTES{seed_byte}};
      end
      upd_we: begin
        en_d   = upd_mask;
        data_d = upd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_bytes   <= '0;
      w_data_bytes <= '0;
    end else begin
      w_en_bytes   <= en_d;
      w_data_bytes <= data_d;
    end
  end

endmodule

// File: rtl/rng_state_ctrl.sv
// Seed loader and write-port arbiter for the RNG state file,
// with an accepted-update counter driving reseed requests.
module rng_state_ctrl
  import rng_pkg::*;
#(
  parameter int          NUM_BYTES       = RNG_NUM_BYTES,
  parameter int          TOTAL_BITS      = 8*NUM_BYTES,
  parameter int unsigned RESEED_INTERVAL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_start,
  input  logic                  seed_valid,
  input  logic [7:0]            seed_data,
  output logic                  seed_ready,
  input  logic                  upd_valid,
  input  logic [NUM_BYTES-1:0]  upd_mask,
  input  logic [TOTAL_BITS-1:0] upd_data,
  output logic                  upd_ready,
  output logic [NUM_BYTES-1:0]  w_en_bytes,
  output logic [TOTAL_BITS-1:0] w_data_bytes,
  output logic                  seeded,
  output logic                  reseed_req
);

  localparam int IDX_W =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_BYTES-1);
  localparam logic [RNG_CNT_W-1:0] RI =
    RNG_CNT_W'(RESEED_INTERVAL);

  rng_state_e           state, state_n;
  logic [IDX_W-1:0]     idx;
  logic [RNG_CNT_W-1:0] upd_cnt;
  logic [RNG_CNT_W-1:0] cnt_inc;
  logic                 seed_acc;
  logic                 upd_acc;
  logic                 enter_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    seed_ready = 1'b0;
    upd_ready  = 1'b0;
    seed_acc   = 1'b0;
    upd_acc    = 1'b0;
    enter_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (seed_start) begin
          state_n    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        seed_ready = 1'b1;
        seed_acc   = seed_valid;
        if (seed_acc && idx == LAST_IDX)
          state_n = DRAIN;
      end
      DRAIN: state_n = READY;
      READY: begin
        // a reseed request wins over a same-cycle update
        upd_ready = upd_valid & ~seed_start;
        upd_acc   = upd_ready;
        if (seed_start) begin
          state_n    = LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cnt_inc = (&upd_cnt) ? upd_cnt
                 : upd_cnt + RNG_CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      upd_cnt    <= '0;
      seeded     <= 1'b0;
      reseed_req <= 1'b0;
    end else begin
      if (enter_load)    idx <= '0;
      else if (seed_acc) idx <= idx + IDX_W'(1);

      if (enter_load)          seeded <= 1'b0;
      else if (state == DRAIN) seeded <= 1'b1;

      if (enter_load) begin
        upd_cnt    <= '0;
        reseed_req <= 1'b0;
      end else if (upd_acc) begin
        upd_cnt <= cnt_inc;
        if (RI != '0 && cnt_inc == RI)
          reseed_req <= 1'b1;
      end
    end
  end

  rng_write_mux #(
    .NUM_BYTES  (NUM_BYTES),
    .TOTAL_BITS (TOTAL_BITS),
    .IDX_W      (IDX_W)
  ) u_wmux (
    .clk          (clk),
    .rst_n        (rst_n),
    .seed_we      (seed_acc),
    .seed_idx     (idx),
    .seed_byte    (seed_data),
    .upd_we       (upd_acc),
    .upd_mask     (upd_mask),
    .upd_data     (upd_data),
    .w_en_bytes   (w_en_bytes),
    .w_data_bytes (w_data_bytes)
  );

endmodule

// File: tb/tb_rng_state_ctrl.sv
// Scoreboard bench for rng_state_ctrl: expected writes are queued
// at handshake time and matched against the write port each cycle.
module tb_rng_state_ctrl;

  localparam int NB = 32;
  localparam int TW = 8*NB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seed_start;
  logic          seed_valid;
  logic [7:0]    seed_data;
  logic          seed_ready;
  logic          upd_valid;
  logic [NB-1:0] upd_mask;
  logic [TW-1:0] upd_data;
  logic          upd_ready;
  logic [NB-1:0] w_en_bytes;
  logic [TW-1:0] w_data_bytes;
  logic          seeded;
  logic          reseed_req;

  typedef struct {
    int            cyc;
    logic [NB-1:0] en;
    logic [TW-1:0] data;
    logic [TW-1:0] care;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] fmem[NB];
  logic [7:0] exp_mem[NB];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  rng_state_ctrl #(
    .NUM_BYTES       (NB),
    .TOTAL_BITS      (TW),
    .RESEED_INTERVAL (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seed_start   (seed_start),
    .seed_valid   (seed_valid),
    .seed_data    (seed_data),
    .seed_ready   (seed_ready),
    .upd_valid    (upd_valid),
    .upd_mask     (upd_mask),
    .upd_data     (upd_data),
    .upd_ready    (upd_ready),
    .w_en_bytes   (w_en_bytes),
    .w_data_bytes (w_data_bytes),
    .seeded       (seeded),
    .reseed_req   (reseed_req)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] care_of(input logic [NB-1:0] m);
    logic [TW-1:0] c;
    for (int i = 0; i < NB; i++) c[8*i +: 8] = {8{m[i]}};
    return c;
  endfunction

  task automatic push_exp(input logic [NB-1:0] en,
                          input logic [TW-1:0] data,
                          input logic [TW-1:0] care);
    exp_t e;
    e.cyc = cyc + 1;
    e.en = en;
    e.data = data;
    e.care = care;
    sbq.push_back(e);
    for (int i = 0; i < NB; i++)
      if (en[i]) exp_mem[i] = data[8*i +: 8];
  endtask

  // one clock; at the falling edge the write port is scored and
  // the modelled state file captures the enabled lanes
  task automatic tick;
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      n_chk++; n_fail++;
      $display("FAIL sb_missed: no write at cyc %0d, required en=%h", e.cyc, e.en);
    end
    if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      n_chk++;
      if (w_en_bytes !== e.en ||
          (w_data_bytes & e.care) !== (e.data & e.care)) begin
        n_fail++;
        $display("FAIL sb_write cyc %0d: en=%h data=%h, required en=%h data=%h (care %h)",
                 cyc, w_en_bytes, w_data_bytes, e.en, e.data, e.care);
      end
    end else begin
      n_chk++;
      if (w_en_bytes !== '0) begin
        n_fail++;
        $display("FAIL sb_idle cyc %0d: en=%h, required 0", cyc, w_en_bytes);
      end
    end
    for (int i = 0; i < NB; i++)
      if (w_en_bytes[i] === 1'b1) fmem[i] = w_data_bytes[8*i +: 8];
  endtask

  task automatic start_seed;
    seed_start = 1'b1;
    #1;
    n_chk++;
    if (seed_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_load_ready: %b, required 0", seed_ready);
    end
    tick;
    seed_start = 1'b0;
    #1;
    n_chk++;
    if (seeded !== 1'b0) begin
      n_fail++;
      $display("FAIL load_seeded: %b, required 0", seeded);
    end
    n_chk++;
    if (seed_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_entry_ready: %b, required 1", seed_ready);
    end
    n_chk++;
    if (reseed_req !== 1'b0) begin
      n_fail++;
      $display("FAIL load_reseed_req: %b, required 0", reseed_req);
    end
  endtask

  // streams NB bytes base+k; gap inserts an idle cycle between bytes;
  // a stray seed_start in LOAD and in DRAIN must be ignored
  task automatic load_bytes(input logic [7:0] base, input bit gap);
    int k;
    bit idle;
    logic [7:0] b;
    k = 0;
    idle = 1'b0;
    for (int it = 0; it < 2*NB && k < NB; it++) begin
      seed_start = (it == 5);
      if (gap && idle) begin
        seed_valid = 1'b0;
      end else begin
        b = base + 8'(k);
        seed_valid = 1'b1;
        seed_data = b;
        push_exp(NB'(1) << k, {NB{b}}, '1);
        k++;
      end
      idle = gap && !idle;
      #1;
      n_chk++;
      if (seed_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_seed_ready it %0d: %b, required 1", it, seed_ready);
      end
      n_chk++;
      if (upd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL load_upd_ready it %0d: %b, required 0", it, upd_ready);
      end
      tick;
    end
    seed_valid = 1'b0;
    seed_start = 1'b1;
    #1;
    n_chk++;
    if (seed_ready !== 1'b0 || upd_ready !== 1'b0 || seeded !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_outputs: seed_ready=%b upd_ready=%b seeded=%b, required 0 0 0",
               seed_ready, upd_ready, seeded);
    end
    tick;
    seed_start = 1'b0;
    #1;
    n_chk++;
    if (seeded !== 1'b1) begin
      n_fail++;
      $display("FAIL seeded_rise: %b, required 1", seeded);
    end
    n_chk++;
    if (seed_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_seed_ready: %b, required 0", seed_ready);
    end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (fmem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL seed_mem[%0d]: %h, required %h", i, fmem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    seed_start = 1'b1;
    seed_valid = 1'b1;
    upd_valid = 1'b1;
    tick;
    tick;
    n_chk++;
    if (w_en_bytes !== '0 || w_data_bytes !== '0 || seed_ready !== 1'b0 ||
        upd_ready !== 1'b0 || seeded !== 1'b0 || reseed_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%h data=%h sr=%b ur=%b sd=%b rr=%b, required all 0",
               w_en_bytes, w_data_bytes, seed_ready, upd_ready, seeded, reseed_req);
    end
    seed_start = 1'b0;
    seed_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    #1;
    n_chk++;
    if (upd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_upd_ready: %b, required 0", upd_ready);
    end
    upd_valid = 1'b0;
    tick;
  endtask

  task automatic test_seed_basic;
    start_seed;
    load_bytes(8'h00, 1'b0);
  endtask

  task automatic test_seed_gapped;
    start_seed;
    load_bytes(8'h60, 1'b1);
  endtask

  task automatic test_update_mask;
    logic [TW-1:0] d;
    for (int w = 0; w < TW/32; w++) d[32*w +: 32] = $urandom();
    d[7:0] = 8'hAA;
    d[15:8] = 8'h55;
    upd_valid = 1'b1;
    upd_mask = 32'h0000_0003;
    upd_data = d;
    #1;
    n_chk++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL upd_ready: %b, required 1", upd_ready);
    end
    push_exp(32'h0000_0003, d, care_of(32'h0000_0003));
    tick;
    upd_valid = 1'b0;
    #1;
    n_chk++;
    if (upd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL upd_ready_drop: %b, required 0", upd_ready);
    end
    tick;
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (fmem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL upd_mem[%0d]: %h, required %h", i, fmem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_seed_priority;
    logic [TW-1:0] d;
    logic [NB-1:0] m;
    for (int w = 0; w < TW/32; w++) d[32*w +: 32] = $urandom();
    m = 32'h0000_F00F;
    upd_valid = 1'b1;
    upd_mask = m;
    upd_data = d;
    seed_start = 1'b1;
    #1;
    n_chk++;
    if (upd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_upd_ready: %b, required 0", upd_ready);
    end
    tick;
    seed_start = 1'b0;
    #1;
    n_chk++;
    if (seeded !== 1'b0 || seed_ready !== 1'b1 || upd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load_entry: seeded=%b seed_ready=%b upd_ready=%b, required 0 1 0",
               seeded, seed_ready, upd_ready);
    end
    load_bytes(8'hC0, 1'b0);
    #1;
    n_chk++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_pending_upd: %b, required 1", upd_ready);
    end
    push_exp(m, d, care_of(m));
    tick;
    upd_valid = 1'b0;
    tick;
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (fmem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL prio_mem[%0d]: %h, required %h", i, fmem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reseed;
    logic [TW-1:0] d;
    logic [NB-1:0] m;
    start_seed;
    load_bytes(8'h80, 1'b0);
    for (int u = 0; u < 5; u++) begin
      for (int w = 0; w < TW/32; w++) d[32*w +: 32] = $urandom();
      m = (u == 2) ? '0 : NB'($urandom());
      upd_valid = 1'b1;
      upd_mask = m;
      upd_data = d;
      #1;
      n_chk++;
      if (upd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reseed_upd_ready u%0d: %b, required 1", u, upd_ready);
      end
      n_chk++;
      if (reseed_req !== (u >= 4)) begin
        n_fail++;
        $display("FAIL reseed_req u%0d: %b, required %b", u, reseed_req, (u >= 4));
      end
      push_exp(m, d, care_of(m));
      tick;
    end
    upd_valid = 1'b0;
    #1;
    n_chk++;
    if (reseed_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reseed_req_hold: %b, required 1", reseed_req);
    end
    start_seed;
    load_bytes(8'h90, 1'b0);
    n_chk++;
    if (reseed_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reseed_req_after_reload: %b, required 0", reseed_req);
    end
  endtask

  task automatic test_reset_midload;
    logic [7:0] b;
    start_seed;
    for (int k = 0; k < 10; k++) begin
      b = 8'h30 + 8'(k);
      seed_valid = 1'b1;
      seed_data = b;
      push_exp(NB'(1) << k, {NB{b}}, '1);
      tick;
    end
    seed_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (w_en_bytes !== '0 || w_data_bytes !== '0 || seed_ready !== 1'b0 ||
        upd_ready !== 1'b0 || seeded !== 1'b0 || reseed_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: en=%h data=%h sr=%b ur=%b sd=%b rr=%b, required all 0",
               w_en_bytes, w_data_bytes, seed_ready, upd_ready, seeded, reseed_req);
    end
    tick;
    tick;
    rst_n = 1'b1;
    seed_valid = 1'b1;
    seed_data = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (seed_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_ready %0d: %b, required 0", k, seed_ready);
      end
      tick;
    end
    seed_valid = 1'b0;
    start_seed;
    load_bytes(8'h40, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    seed_start = 1'b0;
    seed_valid = 1'b0;
    seed_data = '0;
    upd_valid = 1'b0;
    upd_mask = '0;
    upd_data = '0;
    for (int i = 0; i < NB; i++) begin
      fmem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    test_reset;
    test_seed_basic;
    test_seed_gapped;
    test_update_mask;
    test_seed_priority;
    test_reseed;
    test_reset_midload;
    tick;
    tick;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d writes outstanding, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
